// File: rtl/fft_peak_picker_if.sv
// rtl/fft_peak_picker_if.sv - FFT bin stream in, per-frame peak report out; PEAK_SECOND_EN adds runner-up signals
interface fft_peak_picker_if #(
  parameter int DATA_W = 16
);
  logic                     i_valid;
  logic [9:0]               i_fft_cnt;
  logic signed [DATA_W-1:0] i_re;
  logic signed [DATA_W-1:0] i_im;
  logic                     o_peak_valid;
  logic [9:0]               o_peak_bin;
  logic [DATA_W:0]          o_peak_mag;
  logic                     o_note_on;
`ifdef PEAK_SECOND_EN
  logic [9:0]               o_peak2_bin;
  logic [DATA_W:0]          o_peak2_mag;

  modport master (
    output i_valid, i_fft_cnt, i_re, i_im,
    input  o_peak_valid, o_peak_bin, o_peak_mag, o_note_on, o_peak2_bin, o_peak2_mag
  );
  modport slave (
    input  i_valid, i_fft_cnt, i_re, i_im,
    output o_peak_valid, o_peak_bin, o_peak_mag, o_note_on, o_peak2_bin, o_peak2_mag
  );
`else
  modport master (
    output i_valid, i_fft_cnt, i_re, i_im,
    input  o_peak_valid, o_peak_bin, o_peak_mag, o_note_on
  );
  modport slave (
    input  i_valid, i_fft_cnt, i_re, i_im,
    output o_peak_valid, o_peak_bin, o_peak_mag, o_note_on
  );
`endif
endinterface

// File: rtl/fft_peak_picker.sv
// rtl/fft_peak_picker.sv - streaming |re|+|im| peak picker over a bin band, one report per 1024-bin frame
// Optional runner-up tracking is enabled by defining PEAK_SECOND_EN.
module fft_peak_picker #(
  parameter int DATA_W = 16,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511,
  parameter int THRESH = 1024
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fft_peak_picker_if.slave  bus
);
  localparam logic [9:0]      LO      = 10'(BIN_LO);
  localparam logic [9:0]      HI      = 10'(BIN_HI);
  localparam logic [9:0]      LAST    = 10'd1023;
  localparam logic [DATA_W:0] THR     = (DATA_W+1)'(THRESH);
  localparam logic [DATA_W:0] MAG_ZERO = '0;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t state, state_nxt;

  function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] e;
    e = {x[DATA_W-1], x};
    return e[DATA_W] ? $unsigned(-e) : $unsigned(e);
  endfunction

  logic [DATA_W:0] mag_in;
  assign mag_in = abs_ext(bus.i_re) + abs_ext(bus.i_im);

  logic            s1_valid;
  logic [9:0]      s1_bin;
  logic [DATA_W:0] s1_mag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_mag   <= '0;
    end else begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_bin <= bus.i_fft_cnt;
        s1_mag <= mag_in;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  logic s1_first, s1_last;
  assign s1_first = s1_valid && (s1_bin == 10'd0);
  assign s1_last  = s1_valid && (s1_bin == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s1_first) state_nxt = SCAN;
      SCAN:    if (s1_last)  state_nxt = REPORT;
      REPORT:  state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  // take: S1 sample enters the compare; clr: compare against an empty max (new frame or resync)
  logic take, clr, rpt;
  always_comb begin
    take = 1'b0;
    clr  = 1'b0;
    rpt  = 1'b0;
    case (state)
      IDLE: begin
        take = s1_first;
        clr  = 1'b1;
      end
      SCAN: begin
        take = s1_valid;
        clr  = s1_first;
      end
      REPORT: begin
        take = s1_valid;
        clr  = 1'b1;
        rpt  = 1'b1;
      end
      default: ;
    endcase
  end

  logic [DATA_W:0] max_mag, base_mag;
  logic [9:0]      max_bin, base_bin;
  logic            in_band, new_max;

  assign base_mag = clr ? MAG_ZERO : max_mag;
  assign base_bin = clr ? 10'd0 : max_bin;
  assign in_band  = (s1_bin >= LO) && (s1_bin <= HI);
  assign new_max  = take && in_band && (s1_mag > base_mag);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      max_mag <= '0;
      max_bin <= '0;
    end else if (new_max) begin
      max_mag <= s1_mag;
      max_bin <= s1_bin;
    end else begin
      max_mag <= base_mag;
      max_bin <= base_bin;
    end
  end

  // Outputs report the max as it stood before this cycle's sample, which already belongs to the next frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_peak_valid <= 1'b0;
      bus.o_peak_bin   <= '0;
      bus.o_peak_mag   <= '0;
      bus.o_note_on    <= 1'b0;
    end else begin
      bus.o_peak_valid <= rpt;
      if (rpt) begin
        bus.o_peak_bin <= max_bin;
        bus.o_peak_mag <= max_mag;
        bus.o_note_on  <= (max_mag > THR);
      end
    end
  end

`ifdef PEAK_SECOND_EN
  logic [DATA_W:0] sec_mag, base2_mag;
  logic [9:0]      sec_bin, base2_bin;

  assign base2_mag = clr ? MAG_ZERO : sec_mag;
  assign base2_bin = clr ? 10'd0 : sec_bin;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sec_mag <= '0;
      sec_bin <= '0;
    end else if (new_max) begin
      sec_mag <= base_mag;
      sec_bin <= base_bin;
    end else if (take && in_band && (s1_mag > base2_mag)) begin
      sec_mag <= s1_mag;
      sec_bin <= s1_bin;
    end else begin
      sec_mag <= base2_mag;
      sec_bin <= base2_bin;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_peak2_bin <= '0;
      bus.o_peak2_mag <= '0;
    end else if (rpt) begin
      bus.o_peak2_bin <= sec_bin;
      bus.o_peak2_mag <= sec_mag;
    end
  end
`endif
endmodule

// File: tb/tb_fft_peak_picker.sv
// tb/tb_fft_peak_picker.sv - frame vector table with scoreboard, plus resync and mid-frame reset sequences
module tb_fft_peak_picker;
  typedef struct {
    int b0, r0, i0;
    int b1, r1, i1;
    int b2, r2, i2;
    int bg_re, bg_im, gap;
    int e_bin, e_mag, e_note;
    int chk2, e2_bin, e2_mag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  vec_t sb_v[$];
  int   sb_c[$];

  fft_peak_picker_if #(.DATA_W(16)) bus();

  fft_peak_picker #(.DATA_W(16), .BIN_LO(1), .BIN_HI(511), .THRESH(1024)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_bins(input vec_t v, input int lo, input int hi, input bit push);
    int re, im;
    for (int b = lo; b <= hi; b++) begin
      if (v.gap > 0) begin
        while ($urandom_range(99) < v.gap) begin
          @(negedge clk);
          bus.i_valid = 1'b0;
        end
      end
      @(negedge clk);
      re = v.bg_re;
      im = v.bg_im;
      if (b == v.b0) begin re = v.r0; im = v.i0; end
      if (b == v.b1) begin re = v.r1; im = v.i1; end
      if (b == v.b2) begin re = v.r2; im = v.i2; end
      bus.i_valid   = 1'b1;
      bus.i_fft_cnt = 10'(b);
      bus.i_re      = 16'(re);
      bus.i_im      = 16'(im);
      if (push && b == 1023) begin
        sb_v.push_back(v);
        sb_c.push_back(cyc + 3);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    vec_t mv;
    int   mc;
    if (rst_n && bus.o_peak_valid) begin
      if (sb_v.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got pulse bin %0d expected no pulse (cycle %0d)", bus.o_peak_bin, cyc);
      end else begin
        mv = sb_v.pop_front();
        mc = sb_c.pop_front();
        chk("latency", cyc, mc);
        chk("peak_bin", int'(bus.o_peak_bin), mv.e_bin);
        chk("peak_mag", int'(bus.o_peak_mag), mv.e_mag);
        chk("note_on", int'(bus.o_note_on), mv.e_note);
`ifdef PEAK_SECOND_EN
        if (mv.chk2 != 0) begin
          chk("peak2_bin", int'(bus.o_peak2_bin), mv.e2_bin);
          chk("peak2_mag", int'(bus.o_peak2_mag), mv.e2_mag);
        end
`endif
      end
    end
  end

  vec_t vecs[9];
  vec_t v_abort, v_new, v_rst;

  initial begin
    //          b0  r0     i0      b1   r1    i1   b2   r2    i2   bgr bgi gap  bin  mag    note chk2 b2  m2
    vecs[0] = '{100, 3000, -4000,  -1,  0,    0,   -1,  0,    0,   10, 10, 0,   100, 7000,  1,   0,   0,  0};
    vecs[1] = '{700, 30000, 0,     50,  500,  500, 60,  500,  500, 10, 10, 0,   50,  1000,  0,   0,   0,  0};
    vecs[2] = '{5, -32768, -32768, -1,  0,    0,   -1,  0,    0,   10, 10, 0,   5,   65536, 1,   0,   0,  0};
    vecs[3] = '{0,  5000,  5000,   1023, 5000, 5000, 600, 100, 0,  0,  0,  0,   0,   0,     0,   0,   0,  0};
    vecs[4] = '{511, 2000, 0,      512, 5000, 0,   0,   7000, 0,   0,  0,  0,   511, 2000,  1,   0,   0,  0};
    vecs[5] = '{1,  1024,  0,      2,   -512, 512, -1,  0,    0,   0,  0,  0,   1,   1024,  0,   0,   0,  0};
    vecs[6] = '{300, 0,    -1025,  -1,  0,    0,   -1,  0,    0,   0,  0,  0,   300, 1025,  1,   0,   0,  0};
    vecs[7] = '{100, 3000, -4000,  -1,  0,    0,   -1,  0,    0,   10, 10, 30,  100, 7000,  1,   0,   0,  0};
    vecs[8] = '{10,  900,  0,      20,  1000, -500, 30, -600, 600, 0,  0,  0,   20,  1500,  1,   1,   30, 1200};
    v_abort = '{100, 9000, 0,      -1,  0,    0,   -1,  0,    0,   0,  0,  0,   100, 9000,  1,   0,   0,  0};
    v_new   = '{250, 3000, 0,      -1,  0,    0,   -1,  0,    0,   0,  0,  0,   250, 3000,  1,   0,   0,  0};
    v_rst   = v_abort;

    bus.i_valid   = 1'b0;
    bus.i_fft_cnt = '0;
    bus.i_re      = '0;
    bus.i_im      = '0;
    repeat (3) @(negedge clk);
    chk("rst_peak_valid", int'(bus.o_peak_valid), 0);
    chk("rst_peak_bin", int'(bus.o_peak_bin), 0);
    chk("rst_peak_mag", int'(bus.o_peak_mag), 0);
    chk("rst_note_on", int'(bus.o_note_on), 0);
    rst_n = 1'b1;

    foreach (vecs[k]) drive_bins(vecs[k], 0, 1023, 1'b1);

    // Resync: bin counter jumps back to 0 mid-frame; aborted frame must not report
    drive_bins(v_abort, 0, 399, 1'b0);
    drive_bins(v_new, 0, 1023, 1'b1);

    // Mid-frame reset clears outputs asynchronously, partial frame afterwards must stay silent
    drive_bins(v_rst, 0, 300, 1'b0);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    chk("mid_rst_peak_valid", int'(bus.o_peak_valid), 0);
    chk("mid_rst_peak_bin", int'(bus.o_peak_bin), 0);
    chk("mid_rst_peak_mag", int'(bus.o_peak_mag), 0);
    chk("mid_rst_note_on", int'(bus.o_note_on), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_bins(v_rst, 301, 1023, 1'b0);
    drive_bins(vecs[0], 0, 1023, 1'b1);

    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pending_reports", sb_v.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
